fpadd_align_stage: RTL and testbench
====================================

FPADD_ALIGN_STAGE -- requirements
Module: fpadd_align_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with no parameters: clk input 1 rising-edge clock; rst_n input 1 synchronous active-low reset.
REQ-002 in_valid input 1: operand pair a/b valid this cycle.
REQ-003 in_ready output 1: block accepts the pair when in_valid&&in_ready at clk edge.
REQ-004 a input 32, b input 32: IEEE-754 single-precision operands.
REQ-005 out_valid output 1: output bundle valid; out_ready input 1: downstream add/round stage consumes on out_valid&&out_ready.
REQ-006 large_m output 26: two's-complement signed mantissa of larger-magnitude operand, {0,hidden,frac[22:0],guard=0}, negated if its sign=1.
REQ-007 small_m output 26: same format for smaller operand after right shift by exponent difference, negated if its sign=1.
REQ-008 bit_r output 1: OR of all small-operand bits shifted out below small_m[0].
REQ-009 exp_out output 8: effective exponent of larger operand; special output 1: result is Inf/NaN bypass; special_res output 32: bypass result.

Function
REQ-010 The magnitude compare SHALL use unsigned a[30:0] vs b[30:0]; larger is "large"; on tie, a is large.
REQ-011 Hidden bit SHALL be 1 if exponent!=0, else 0 with effective exponent 1 (denormal).
REQ-012 d SHALL be eff_exp_large - eff_exp_small (8-bit, never negative); if d>=26, small_m=0 and bit_r=OR of whole unshifted small mantissa.
REQ-013 Negation SHALL be 26-bit two's complement (~x+1) applied after shift; bit_r is computed on the magnitude, before negation.
REQ-014 NaN: if either operand has exp=FF and frac!=0, or operands are +Inf and -Inf, special=1 and special_res=32'h7FC00000.
REQ-015 Inf: otherwise, if any operand is Inf, special=1 and special_res=that Inf (both Inf with same sign: that Inf).
REQ-016 When special=1, large_m, small_m, bit_r and exp_out SHALL be 0; zeros and denormals are not special.
REQ-017 Latency SHALL be 1 cycle from acceptance to out_valid when not stalled; throughput 1 pair/cycle.
REQ-018 Buffering SHALL be a 2-entry skid buffer with FSM states EMPTY, ONE, TWO.
REQ-019 EMPTY->ONE on accept; ONE->ONE on accept+consume; ONE->TWO on accept without consume; ONE->EMPTY on consume without accept; TWO->ONE on consume.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; registered, not combinationally dependent on out_ready.
REQ-021 Outputs SHALL be presented in acceptance order; the entry shown while out_valid=1 SHALL NOT change until consumed.
REQ-022 In TWO, in_valid with in_ready=0 SHALL be ignored; no entry is dropped or duplicated.

Reset
REQ-023 While rst_n=0 at a clk edge: state=EMPTY, out_valid=0, in_ready=0, all data outputs 0.
REQ-024 The first cycle after rst_n returns 1, in_ready SHALL be 1.
REQ-025 Reset mid-operation SHALL discard all buffered entries; no pre-reset entry is emitted afterwards.

Verification
REQ-026 a=3F800000, b=3F800000, out_ready=1 -> next cycle out_valid=1, exp_out=7F, large_m=0x1000000, small_m=0x1000000, bit_r=0, special=0.
REQ-027 a=3F800000, b=BF000000 -> exp_out=7F, large_m=0x1000000, small_m=0x3800000, bit_r=0.
REQ-028 a=4B800000, b=3F800001 (d=24) -> exp_out=97, small_m=0x0000001, bit_r=1; swapped a/b -> identical outputs.
REQ-029 a=7F800000, b=FF800000 -> special=1, special_res=7FC00000, large_m=small_m=0; a=7F800000, b=3F800000 -> special_res=7F800000.
REQ-030 Three back-to-back pairs with out_ready=0 -> two accepted, in_ready=0 on third; then out_ready=1 -> three outputs in order on consecutive cycles, none lost.
REQ-031 State TWO, rst_n=0 for one cycle -> out_valid=0, in_ready=0 that cycle, in_ready=1 next; no stale output ever appears.

Source files
------------

// File: rtl/fpadd_align_stage_if.sv
// Handshake/bus bundle for the FP-add alignment stage.
// Upstream side: in_valid/in_ready with operands a, b (IEEE-754 single).
// Downstream side: out_valid/out_ready with the aligned bundle
//   large_m, small_m (26-bit two's-complement mantissas), bit_r (sticky),
//   exp_out (effective exponent), special/special_res (Inf/NaN bypass).
// master: the environment that feeds operands and consumes results.
// slave:  the alignment stage itself.
interface fpadd_align_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] large_m;
  logic [25:0] small_m;
  logic        bit_r;
  logic [7:0]  exp_out;
  logic        special;
  logic [31:0] special_res;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, large_m, small_m, bit_r, exp_out, special, special_res
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, large_m, small_m, bit_r, exp_out, special, special_res
  );
endinterface

// File: rtl/fpadd_align_stage.sv
// Alignment stage of a single-precision floating-point adder.
// Picks the larger-magnitude operand, right-shifts the smaller mantissa by the
// exponent difference (collecting shifted-out bits into bit_r), applies signs
// as 26-bit two's complement and detects Inf/NaN bypass results. Results are
// held in a 2-entry skid buffer so in_ready never depends on out_ready.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of fpadd_align_stage_if (operand in, aligned bundle out)
module fpadd_align_stage (
  input logic                clk,
  input logic                rst_n,
  fpadd_align_stage_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [25:0] large_m;
    logic [25:0] small_m;
    logic        bit_r;
    logic [7:0]  exp_out;
    logic        special;
    logic [31:0] special_res;
  } entry_t;

  state_e state_q, state_d;
  logic   in_ready_q;
  entry_t head_q, tail_q;
  entry_t align_res;
  logic   out_valid;
  logic   accept, consume;

  // Alignment datapath
  logic        a_large;
  logic [31:0] op_l, op_s;
  logic [7:0]  exp_l, exp_s, diff;
  logic [25:0] mag_l, mag_s, sh_s;
  logic        sticky;
  logic        nan_a, nan_b, inf_a, inf_b;

  always_comb begin
    // Tie goes to a.
    a_large = (bus.a[30:0] >= bus.b[30:0]);
    op_l    = a_large ? bus.a : bus.b;
    op_s    = a_large ? bus.b : bus.a;
    // Denormals and zero use effective exponent 1 with hidden bit 0.
    exp_l   = (op_l[30:23] == 8'd0) ? 8'd1 : op_l[30:23];
    exp_s   = (op_s[30:23] == 8'd0) ? 8'd1 : op_s[30:23];
    mag_l   = {1'b0, |op_l[30:23], op_l[22:0], 1'b0};
    mag_s   = {1'b0, |op_s[30:23], op_s[22:0], 1'b0};
    diff    = exp_l - exp_s;
    if (diff >= 8'd26) begin
      sh_s   = '0;
      sticky = |mag_s;
    end else begin
      sh_s   = mag_s >> diff;
      sticky = |(mag_s & ~({26{1'b1}} << diff));
    end

    nan_a = (&bus.a[30:23]) && (|bus.a[22:0]);
    nan_b = (&bus.b[30:23]) && (|bus.b[22:0]);
    inf_a = (&bus.a[30:23]) && !(|bus.a[22:0]);
    inf_b = (&bus.b[30:23]) && !(|bus.b[22:0]);

    align_res = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (bus.a[31] != bus.b[31]))) begin
      align_res.special     = 1'b1;
      align_res.special_res = 32'h7FC0_0000;
    end else if (inf_a || inf_b) begin
      align_res.special     = 1'b1;
      align_res.special_res = inf_a ? bus.a : bus.b;
    end else begin
      // Sticky is taken on the magnitude, before negation.
      align_res.large_m = op_l[31] ? (~mag_l + 26'd1) : mag_l;
      align_res.small_m = op_s[31] ? (~sh_s + 26'd1) : sh_s;
      align_res.bit_r   = sticky;
      align_res.exp_out = exp_l;
    end
  end

  assign accept  = bus.in_valid && in_ready_q;
  assign consume = out_valid && bus.out_ready;

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !consume)      state_d = StTwo;
        else if (!accept && consume) state_d = StEmpty;
      end
      StTwo:   if (consume) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // Skid storage: head is what the outputs show, tail catches one extra entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        StEmpty: if (accept) head_q <= align_res;
        StOne: begin
          if (accept && consume) head_q <= align_res;
          else if (accept)       tail_q <= align_res;
        end
        StTwo:   if (consume) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    out_valid       = (state_q != StEmpty);
    bus.out_valid   = out_valid;
    bus.in_ready    = in_ready_q;
    bus.large_m     = head_q.large_m;
    bus.small_m     = head_q.small_m;
    bus.bit_r       = head_q.bit_r;
    bus.exp_out     = head_q.exp_out;
    bus.special     = head_q.special;
    bus.special_res = head_q.special_res;
  end

endmodule

// File: tb/tb_fpadd_align_stage.sv
// Self-checking bench for fpadd_align_stage: directed vector table, handshake
// corner sequences and randomized traffic against an arithmetic reference model.
module tb_fpadd_align_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fpadd_align_stage_if bus ();

  fpadd_align_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0] lm;
    logic [25:0] sm;
    logic        r;
    logic [7:0]  e;
    logic        sp;
    logic [31:0] res;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    res_t        want;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  bit   use_model = 1'b0;
  bit   hold_seen = 1'b0;
  res_t hold_val;
  res_t q[$];
  res_t got;

  assign got = {bus.large_m, bus.small_m, bus.bit_r, bus.exp_out, bus.special, bus.special_res};

  task automatic check_res(input string name, input res_t g, input res_t w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got lm=%h sm=%h r=%b e=%h sp=%b res=%h; want lm=%h sm=%h r=%b e=%h sp=%b res=%h",
               name, g.lm, g.sm, g.r, g.e, g.sp, g.res, w.lm, w.sm, w.r, w.e, w.sp, w.res);
    end
  endtask

  task automatic check_bit(input string name, input logic g, input logic w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, g, w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: real mantissa arithmetic on integers.
  function automatic longint sig2(input logic [31:0] x);
    longint s;
    s = longint'(x[22:0]);
    if (x[30:23] != 8'd0) s = s + (64'd1 << 23);
    return s * 2;
  endfunction

  function automatic int eff_exp(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
  endfunction

  function automatic logic [25:0] enc(input bit neg, input longint m);
    longint v;
    v = neg ? (((64'd1 << 26) - m) % (64'd1 << 26)) : m;
    return v[25:0];
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    bit          nan_a, nan_b, inf_a, inf_b;
    logic [31:0] lo, so;
    longint      ml, ms, shifted, p;
    int          d, el;
    r     = '0;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (nan_a || nan_b || (inf_a && inf_b && a[31] != b[31])) begin
      r.sp  = 1'b1;
      r.res = 32'h7FC0_0000;
      return r;
    end
    if (inf_a || inf_b) begin
      r.sp  = 1'b1;
      r.res = inf_a ? a : b;
      return r;
    end
    if (a[30:0] >= b[30:0]) begin lo = a; so = b; end
    else begin lo = b; so = a; end
    ml = sig2(lo);
    ms = sig2(so);
    el = eff_exp(lo);
    d  = el - eff_exp(so);
    if (d >= 26) begin
      shifted = 0;
      r.r     = (ms != 0);
    end else begin
      p       = 64'd1 << d;
      shifted = ms / p;
      r.r     = (ms % p) != 0;
    end
    r.lm = enc(lo[31], ml);
    r.sm = enc(so[31], shifted);
    r.e  = el[7:0];
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    int          k;
    logic [31:0] v;
    k = $urandom_range(0, 9);
    v = $urandom;
    case (k)
      0: v[30:23] = 8'd0;
      1: v[30:0]  = '0;
      2: v[30:0]  = {8'hFF, 23'd0};
      3: v[30:23] = 8'hFF;
      default: ;
    endcase
    return v;
  endfunction

  // Scoreboard monitor: samples on the falling edge, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        hold_seen = 1'b0;
      end else if (use_model) begin
        if (hold_seen) begin
          check_bit("hold_valid", bus.out_valid, 1'b1);
          if (bus.out_valid) check_res("hold_stable", got, hold_val);
          hold_seen = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got valid output, want none pending");
          end else begin
            check_res("scoreboard", got, q.pop_front());
          end
        end
        if (bus.out_valid && !bus.out_ready) begin
          hold_seen = 1'b1;
          hold_val  = got;
        end
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b));
      end
    end
  end

  vec_t vecs[12];

  initial begin
    int          base;
    int          ex;
    logic [31:0] ra, rb;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, '{26'h1000000, 26'h1000000, 1'b0, 8'h7F, 1'b0, 32'h0}};
    vecs[1]  = '{32'h3F800000, 32'hBF000000, '{26'h1000000, 26'h3800000, 1'b0, 8'h7F, 1'b0, 32'h0}};
    vecs[2]  = '{32'h4B800000, 32'h3F800001, '{26'h1000000, 26'h0000001, 1'b1, 8'h97, 1'b0, 32'h0}};
    vecs[3]  = '{32'h3F800001, 32'h4B800000, '{26'h1000000, 26'h0000001, 1'b1, 8'h97, 1'b0, 32'h0}};
    vecs[4]  = '{32'h7F800000, 32'hFF800000, '{26'h0, 26'h0, 1'b0, 8'h00, 1'b1, 32'h7FC00000}};
    vecs[5]  = '{32'h7F800000, 32'h3F800000, '{26'h0, 26'h0, 1'b0, 8'h00, 1'b1, 32'h7F800000}};
    vecs[6]  = '{32'h00000000, 32'h00000000, '{26'h0, 26'h0, 1'b0, 8'h01, 1'b0, 32'h0}};
    vecs[7]  = '{32'h4F800000, 32'h3F800000, '{26'h1000000, 26'h0, 1'b1, 8'h9F, 1'b0, 32'h0}};
    vecs[8]  = '{32'hBF800000, 32'h3F800000, '{26'h3000000, 26'h1000000, 1'b0, 8'h7F, 1'b0, 32'h0}};
    vecs[9]  = '{32'h3F800000, 32'h7F800001, '{26'h0, 26'h0, 1'b0, 8'h00, 1'b1, 32'h7FC00000}};
    vecs[10] = '{32'hFF800000, 32'hFF800000, '{26'h0, 26'h0, 1'b0, 8'h00, 1'b1, 32'hFF800000}};
    vecs[11] = '{32'h00000001, 32'h00000000, '{26'h0000002, 26'h0, 1'b0, 8'h01, 1'b0, 32'h0}};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_bit("reset_out_valid", bus.out_valid, 1'b0);
    check_bit("reset_in_ready", bus.in_ready, 1'b0);
    check_res("reset_data", got, '0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_bit("post_reset_in_ready", bus.in_ready, 1'b1);
    tick();

    // Directed table
    foreach (vecs[i]) begin
      bus.a         = vecs[i].a;
      bus.b         = vecs[i].b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_bit($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      check_res($sformatf("vec%0d_data", i), got, vecs[i].want);
      tick();
    end
    @(negedge clk);
    check_bit("table_drained", bus.out_valid, 1'b0);
    tick();

    // Three back-to-back pairs with a stalled consumer
    use_model     = 1'b1;
    base          = n_out;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 32'h40000000; bus.b = 32'h3F800000;
    tick();
    bus.a = 32'h40400000; bus.b = 32'hC0000000;
    @(negedge clk);
    check_bit("bb_ready_one", bus.in_ready, 1'b1);
    tick();
    bus.a = 32'h41000000; bus.b = 32'h3E000000;
    @(negedge clk);
    check_bit("bb_ready_two", bus.in_ready, 1'b0);
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_bit("bb_third_refused", bus.in_ready, 1'b0);
    check_bit("bb_valid_e3", bus.out_valid, 1'b1);
    tick();
    @(negedge clk);
    check_bit("bb_valid_e4", bus.out_valid, 1'b1);
    check_bit("bb_ready_back", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_bit("bb_valid_e5", bus.out_valid, 1'b1);
    tick();
    @(negedge clk);
    check_bit("bb_empty", bus.out_valid, 1'b0);
    checks++;
    if (n_out - base != 3 || q.size() != 0) begin
      errors++;
      $display("FAIL bb_count: got %0d outputs (%0d pending), want 3 (0 pending)",
               n_out - base, q.size());
    end
    tick();

    // Reset while holding two entries
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 32'h3F800000; bus.b = 32'h3F000000;
    tick();
    bus.a = 32'h42000000; bus.b = 32'hC1000000;
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    @(negedge clk);
    check_bit("midrst_out_valid", bus.out_valid, 1'b0);
    check_bit("midrst_in_ready", bus.in_ready, 1'b0);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    check_bit("midrst_ready_after", bus.in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_bit("midrst_no_stale", bus.out_valid, 1'b0);
      @(negedge clk);
    end
    tick();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      ra = rnd_op();
      rb = rnd_op();
      if ($urandom_range(0, 1) == 1 && ra[30:23] != 8'hFF) begin
        ex = int'(ra[30:23]) - int'($urandom_range(0, 30));
        if (ex < 0) ex = 0;
        rb[30:23] = 8'(ex);
      end
      bus.a         = ra;
      bus.b         = rb;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Drain with a bounded wait
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0 || bus.out_valid) begin
      errors++;
      $display("FAIL drain: got %0d pending, out_valid=%b; want 0 pending, 0", q.size(),
               bus.out_valid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
